uart_tx_buffered: RTL and testbench

- Buffered 8N1 UART transmitter on the console path: core store to address 0x0, then byte FIFO, then serial TXD pin.
- Decouples single-cycle core byte writes from the slow serial line, so console bytes are not lost while a frame is in flight.
- Sits directly downstream of the core/top store-decode logic. Accepts the low byte of the store data plus a write strobe; drives the TXD pad.

---
 rtl/uart_tx_buffered_pkg.sv | 18 +
 rtl/uart_tx_buffered_fifo.sv | 57 +++++
 rtl/uart_tx_buffered.sv | 129 ++++++++++++
 tb/tb_uart_tx_buffered.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_buffered_pkg.sv
// rtl/uart_tx_buffered_pkg.sv - shared UART frame constants and serializer state encoding
package uart_tx_buffered_pkg;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam int   DATA_BITS = 8;

    // 100 MHz board clock at 115200 baud
    localparam int DEFAULT_CLKS_PER_BIT = 868;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/uart_tx_buffered_fifo.sv
// rtl/uart_tx_buffered_fifo.sv - synchronous FIFO with combinational head and level count
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] level
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // full/empty come from the registered level, so a push while full is refused even if a pop happens
    assign full     = (level == CNT_W'(DEPTH));
    assign empty    = (level == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // storage array: written on accepted pushes only, no reset needed
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + CNT_W'(1);
                2'b01:   level <= level - CNT_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// rtl/uart_tx_buffered.sv - buffered 8N1 UART transmitter: byte FIFO feeding a registered serializer
module uart_tx_buffered
    import uart_tx_buffered_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int CNT_W        = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [7:0]       wr_data,
    output logic             txd,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] level,
    output logic             busy,
    output logic             overflow
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    tx_state_t         state;
    logic [BAUD_W-1:0] baud_cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        shift;
    logic [7:0]        head;
    logic              baud_last;
    logic              pop;

    assign baud_last = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));

    // the serializer pops either from idle or at the very end of a stop bit (no gap between frames)
    assign pop  = !empty && ((state == IDLE) || (state == STOP && baud_last));
    assign busy = (state != IDLE) || (level != '0);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (wr_en),
        .push_data (wr_data),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty),
        .level     (level)
    );

    // sticky record of any push refused because the FIFO was full
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (wr_en && full) begin
            overflow <= 1'b1;
        end
    end

    // serializer FSM; txd is driven from the transition itself so each bit starts on the same edge as its state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            txd      <= STOP_BIT;
        end else begin
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    txd      <= STOP_BIT;
                    if (pop) begin
                        shift <= head;
                        state <= START;
                        txd   <= START_BIT;
                    end
                end
                START: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= DATA;
                        txd      <= shift[0];
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                DATA: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'(DATA_BITS - 1)) begin
                            state <= STOP;
                            txd   <= STOP_BIT;
                        end else begin
                            shift   <= {1'b0, shift[7:1]};
                            bit_idx <= bit_idx + 3'd1;
                            txd     <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                STOP: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (pop) begin
                            shift <= head;
                            state <= START;
                            txd   <= START_BIT;
                        end else begin
                            state <= IDLE;
                            txd   <= STOP_BIT;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    txd   <= STOP_BIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb/tb_uart_tx_buffered.sv - self-checking bench for uart_tx_buffered
module tb_uart_tx_buffered;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int CNT_W = 3;
    localparam int FRAME = 10 * CPB;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             wr_en = 1'b0;
    logic [7:0]       wr_data = 8'h00;
    logic             txd;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] level;
    logic             busy;
    logic             overflow;

    int         tests = 0;
    int         fails = 0;
    int         frames = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic       we;
        logic [7:0] data;
        logic       txd;
        logic [2:0] level;
        logic       busy;
    } vec_t;

    vec_t tbl[42];

    uart_tx_buffered #(
        .DEPTH        (DEPTH),
        .CLKS_PER_BIT (CPB),
        .CNT_W        (CNT_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .txd      (txd),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .busy     (busy),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] d, input bit accept);
        wr_en   = 1'b1;
        wr_data = d;
        if (accept) exp_q.push_back(d);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_busy"}, 32'(busy), 0);
        check({name, "_pending"}, 32'(exp_q.size()), 0);
    endtask

    // serial receiver: samples mid-bit, compares each decoded byte against the scoreboard
    initial begin : monitor
        logic [7:0] b;
        bit         abort;
        forever begin
            @(negedge clk);
            if (!reset && txd === 1'b0) begin
                abort = 1'b0;
                repeat (CPB / 2) begin @(negedge clk); if (reset) abort = 1'b1; end
                if (!abort) check("rx_start", 32'(txd), 0);
                for (int k = 0; k < 8; k++) begin
                    repeat (CPB) begin @(negedge clk); if (reset) abort = 1'b1; end
                    b[k] = txd;
                end
                repeat (CPB) begin @(negedge clk); if (reset) abort = 1'b1; end
                if (!abort) begin
                    check("rx_stop", 32'(txd), 1);
                    frames++;
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL rx_extra_frame: actual=%0h required=no frame", b);
                    end else begin
                        check("rx_byte", 32'(b), 32'(exp_q.pop_front()));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [9:0] fr;
        int         f0;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_txd", 32'(txd), 1);
        check("rst_empty", 32'(empty), 1);
        reset = 1'b0;
        @(negedge clk);
        check("idle_txd", 32'(txd), 1);
        check("idle_full", 32'(full), 0);
        check("idle_empty", 32'(empty), 1);
        check("idle_level", 32'(level), 0);
        check("idle_busy", 32'(busy), 0);
        check("idle_ovf", 32'(overflow), 0);

        // single byte 0x41, cycle-exact vectors
        fr = {1'b1, 8'h41, 1'b0};
        tbl[0] = '{1'b1, 8'h41, 1'b1, 3'd1, 1'b1};
        for (int i = 1; i <= 40; i++) tbl[i] = '{1'b0, 8'h00, fr[(i - 1) / CPB], 3'd0, 1'b1};
        tbl[41] = '{1'b0, 8'h00, 1'b1, 3'd0, 1'b0};
        for (int i = 0; i < 42; i++) begin
            wr_en   = tbl[i].we;
            wr_data = tbl[i].data;
            if (tbl[i].we) exp_q.push_back(tbl[i].data);
            @(negedge clk);
            check($sformatf("vec%0d_txd", i), 32'(txd), 32'(tbl[i].txd));
            check($sformatf("vec%0d_level", i), 32'(level), 32'(tbl[i].level));
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
        end
        wr_en = 1'b0;
        repeat (2) @(negedge clk);
        check("single_pending", 32'(exp_q.size()), 0);

        // burst of three, continuous 120-cycle run
        push(8'h55, 1'b1);
        check("burst_lvl0", 32'(level), 1);
        push(8'hA3, 1'b1);
        check("burst_lvl1", 32'(level), 1);
        push(8'h0F, 1'b1);
        check("burst_lvl2", 32'(level), 2);
        repeat (118) @(negedge clk);
        check("burst_busy_end", 32'(busy), 1);
        @(negedge clk);
        check("burst_idle", 32'(busy), 0);
        check("burst_pending", 32'(exp_q.size()), 0);
        repeat (2) @(negedge clk);

        // overflow: six pushes, sixth dropped
        f0 = frames;
        for (int i = 0; i < 6; i++) push(8'(8'hC0 + i), i < 5);
        check("ovf_full", 32'(full), 1);
        check("ovf_level", 32'(level), 4);
        check("ovf_flag", 32'(overflow), 1);
        wait_idle("ovf_drain", 400);
        check("ovf_frames", 32'(frames - f0), 5);
        check("ovf_sticky", 32'(overflow), 1);

        // asynchronous reset during a start bit
        push(8'h00, 1'b1);
        repeat (2) @(negedge clk);
        check("arst_pre_txd", 32'(txd), 0);
        #2 reset = 1'b1;
        exp_q.delete();
        #1;
        check("arst_txd", 32'(txd), 1);
        check("arst_level", 32'(level), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_ovf", 32'(overflow), 0);
        check("arst_empty", 32'(empty), 1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (45) @(negedge clk);

        // wrap-around: ten bytes, one per frame
        for (int i = 0; i < 10; i++) begin
            push(8'(i * 37 + 5), 1'b1);
            repeat (FRAME - 1) @(negedge clk);
        end
        wait_idle("wrap_drain", 200);
        check("wrap_empty", 32'(empty), 1);
        check("wrap_level", 32'(level), 0);

        // reset mid-frame during data bit 3 with two bytes queued
        push(8'hF0, 1'b1);
        push(8'h11, 1'b1);
        push(8'h22, 1'b1);
        repeat (16) @(negedge clk);
        check("mid_pre_txd", 32'(txd), 0);
        check("mid_pre_level", 32'(level), 2);
        #2 reset = 1'b1;
        exp_q.delete();
        #1;
        check("mid_txd", 32'(txd), 1);
        check("mid_level", 32'(level), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        f0 = frames;
        repeat (60) begin
            @(negedge clk);
            if (txd !== 1'b1) break;
        end
        check("mid_after_txd", 32'(txd), 1);
        check("mid_after_frames", 32'(frames - f0), 0);
        check("mid_after_level", 32'(level), 0);
        check("mid_after_empty", 32'(empty), 1);
        check("mid_after_busy", 32'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
